regfile_ckpt: RTL and testbench

- Parametrised multi-entry register file: NUM_REGS entries of WIDTH bits, one write port, two read ports.
- Adds a one-cycle checkpoint/restore shadow bank for speculative or rollback use, e.g. reverting game or CPU state.
- Sits between the datapath and the control FSM; replaces hand-instantiated fixed-width register banks.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/reg_param.sv | 20 ++
 rtl/regfile_ckpt.sv | 101 ++++++++++
 tb/tb_regfile_ckpt.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the checkpointed register file.
package regfile_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef logic [DATA_W_DEFAULT-1:0] data_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WRITE,
    SRC_RESTORE
  } commit_src_e;

  function automatic int addr_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/reg_param.sv
// WIDTH-wide register with load enable and asynchronous active-low clear.
module reg_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_ckpt.sv
// Register file (1W/2R) with a single-snapshot shadow bank for save/restore.
// Optional write-through read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_ckpt
  import regfile_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_REGS  = 32,
  parameter int ZERO_REG0 = 1,
  localparam int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] read_addr_a,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [WIDTH-1:0]  read_data_a,
  output logic [WIDTH-1:0]  read_data_b,
  input  logic              ckpt_save,
  input  logic              ckpt_restore,
  output logic              ckpt_valid,
  output logic              busy_restore
);

  logic [WIDTH-1:0] live_q   [NUM_REGS];
  logic [WIDTH-1:0] shadow_q [NUM_REGS];
  logic             restore_go;

  assign restore_go = ckpt_restore && ckpt_valid;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    localparam bit WRITABLE = (ZERO_REG0 == 0) || (i != 0);

    commit_src_e      src;
    logic             live_en;
    logic [WIDTH-1:0] live_d;

    // Restore outranks a same-edge write to the entry.
    always_comb begin
      src = SRC_NONE;
      if (restore_go) begin
        src = SRC_RESTORE;
      end else if (write_enable && (write_addr == ADDR_W'(i))) begin
        src = SRC_WRITE;
      end
    end

    assign live_en = WRITABLE && (src != SRC_NONE);
    assign live_d  = (src == SRC_RESTORE) ? shadow_q[i] : write_data;

    reg_param #(.WIDTH(WIDTH)) u_live (
      .clk   (clk),
      .reset (reset),
      .en    (live_en),
      .d     (live_d),
      .q     (live_q[i])
    );

    // Shadow samples pre-edge live values, so save+restore swaps the banks.
    reg_param #(.WIDTH(WIDTH)) u_shadow (
      .clk   (clk),
      .reset (reset),
      .en    (ckpt_save),
      .d     (live_q[i]),
      .q     (shadow_q[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ckpt_valid   <= 1'b0;
      busy_restore <= 1'b0;
    end else begin
      busy_restore <= restore_go;
      if (ckpt_save) begin
        ckpt_valid <= 1'b1;
      end else if (restore_go) begin
        ckpt_valid <= 1'b0;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic bypass_ok;
  assign bypass_ok = write_enable && !restore_go &&
                     !((ZERO_REG0 != 0) && (write_addr == '0));
`endif

  always_comb begin
    read_data_a = live_q[read_addr_a];
    read_data_b = live_q[read_addr_b];
    if ((ZERO_REG0 != 0) && (read_addr_a == '0)) read_data_a = '0;
    if ((ZERO_REG0 != 0) && (read_addr_b == '0)) read_data_b = '0;
`ifdef REGFILE_BYPASS_EN
    if (bypass_ok && (write_addr == read_addr_a)) read_data_a = write_data;
    if (bypass_ok && (write_addr == read_addr_b)) read_data_b = write_data;
`endif
  end

endmodule

// File: tb/tb_regfile_ckpt.sv
// Self-checking bench for regfile_ckpt with a high-level array model.
module tb_regfile_ckpt;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr_a;
  logic [4:0]  read_addr_b;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;
  logic        ckpt_save;
  logic        ckpt_restore;
  logic        ckpt_valid;
  logic        busy_restore;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] m_live   [32];
  logic [31:0] m_shadow [32];
  bit          m_valid;
  bit          m_busy;

  regfile_ckpt #(.WIDTH(32), .NUM_REGS(32), .ZERO_REG0(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_addr_a  (read_addr_a),
    .read_addr_b  (read_addr_b),
    .read_data_a  (read_data_a),
    .read_data_b  (read_data_b),
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
    .ckpt_valid   (ckpt_valid),
    .busy_restore (busy_restore)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'h0 : m_live[a];
`ifdef REGFILE_BYPASS_EN
    if (write_enable && write_addr == a && a != 5'd0 && !(ckpt_restore && m_valid))
      v = write_data;
`endif
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_live[i]   = '0;
      m_shadow[i] = '0;
    end
    m_valid = 0;
    m_busy  = 0;
  endtask

  task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit save, input bit restore);
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    ckpt_save    = save;
    ckpt_restore = restore;
  endtask

  // Advance one edge, update the model from the rules, then idle the controls.
  task automatic tick();
    logic [31:0] nl [32];
    bit go;
    @(posedge clk);
    go = ckpt_restore && m_valid;
    nl = m_live;
    if (go) nl = m_shadow;
    else if (write_enable) nl[write_addr] = write_data;
    nl[0] = '0;
    if (ckpt_save) m_shadow = m_live;
    m_live  = nl;
    m_valid = ckpt_save ? 1'b1 : (go ? 1'b0 : m_valid);
    m_busy  = go;
    #1;
    drive(0, 0, 0, 0, 0);
    #1;
  endtask

  task automatic test_reset();
    read_addr_a = 5'd5; read_addr_b = 5'd0; #1;
    tests_run++;
    if (read_data_a !== 32'h0 || ckpt_valid !== 1'b0 || busy_restore !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_init: got a=%h valid=%b busy=%b want 0/0/0", read_data_a, ckpt_valid, busy_restore);
    end
    drive(1, 5, 32'hDEADBEEF, 0, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    tests_run++;
    if (read_data_a !== 32'hDEADBEEF || ckpt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_prewrite: got r5=%h valid=%b want deadbeef/1", read_data_a, ckpt_valid);
    end
    #1 reset = 1'b0;
    model_clear();
    #1;
    tests_run++;
    if (read_data_a !== 32'h0 || ckpt_valid !== 1'b0 || busy_restore !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: got r5=%h valid=%b busy=%b want 0/0/0", read_data_a, ckpt_valid, busy_restore);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 1); tick();
    tests_run++;
    if (read_data_a !== 32'h0 || busy_restore !== 1'b0 || ckpt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_shadow_cleared: got r5=%h busy=%b valid=%b want 0/0/0", read_data_a, busy_restore, ckpt_valid);
    end
  endtask

  task automatic test_basic_write();
    drive(1, 3, 32'h1234, 0, 0); tick();
    read_addr_a = 5'd3; read_addr_b = 5'd0; #1;
    tests_run++;
    if (read_data_a !== 32'h1234 || read_data_b !== 32'h0) begin
      tests_failed++;
      $display("FAIL basic_rw: got a=%h b=%h want 1234/0", read_data_a, read_data_b);
    end
    drive(1, 0, 32'hFFFF, 0, 0); tick();
    read_addr_a = 5'd0; #1;
    tests_run++;
    if (read_data_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL zero_reg: got %h want 0", read_data_a);
    end
  endtask

  task automatic test_ckpt_restore();
    read_addr_a = 5'd7;
    drive(1, 7, 32'hAA, 0, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    tests_run++;
    if (ckpt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL save_valid: got %b want 1", ckpt_valid);
    end
    drive(1, 7, 32'hBB, 0, 0); tick();
    tests_run++;
    if (read_data_a !== 32'hBB) begin
      tests_failed++;
      $display("FAIL post_save_write: got %h want bb", read_data_a);
    end
    drive(0, 0, 0, 0, 1); tick();
    tests_run++;
    if (read_data_a !== 32'hAA || busy_restore !== 1'b1 || ckpt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL restore: got r7=%h busy=%b valid=%b want aa/1/0", read_data_a, busy_restore, ckpt_valid);
    end
    tick();
    tests_run++;
    if (busy_restore !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_one_cycle: got %b want 0", busy_restore);
    end
    drive(1, 7, 32'hCC, 0, 0); tick();
    drive(0, 0, 0, 0, 1); tick();
    tests_run++;
    if (read_data_a !== 32'hCC || busy_restore !== 1'b0 || ckpt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL second_restore: got r7=%h busy=%b valid=%b want cc/0/0", read_data_a, busy_restore, ckpt_valid);
    end
  endtask

  task automatic test_restore_write();
    read_addr_b = 5'd2;
    drive(1, 2, 32'h11, 0, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    drive(1, 2, 32'h99, 0, 1); tick();
    tests_run++;
    if (read_data_b !== 32'h11 || busy_restore !== 1'b1) begin
      tests_failed++;
      $display("FAIL restore_beats_write: got r2=%h busy=%b want 11/1", read_data_b, busy_restore);
    end
  endtask

  task automatic test_swap();
    read_addr_a = 5'd4;
    drive(1, 4, 32'h9, 0, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    drive(1, 4, 32'h5, 0, 0); tick();
    drive(0, 0, 0, 1, 1); tick();
    tests_run++;
    if (read_data_a !== 32'h9 || ckpt_valid !== 1'b1 || busy_restore !== 1'b1) begin
      tests_failed++;
      $display("FAIL swap: got r4=%h valid=%b busy=%b want 9/1/1", read_data_a, ckpt_valid, busy_restore);
    end
    drive(0, 0, 0, 0, 1); tick();
    tests_run++;
    if (read_data_a !== 32'h5 || ckpt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL swap_shadow: got r4=%h valid=%b want 5/0", read_data_a, ckpt_valid);
    end
    drive(1, 4, 32'h6, 0, 0); tick();
    drive(0, 0, 0, 1, 1); tick();
    tests_run++;
    if (read_data_a !== 32'h6 || ckpt_valid !== 1'b1 || busy_restore !== 1'b0) begin
      tests_failed++;
      $display("FAIL save_restore_invalid: got r4=%h valid=%b busy=%b want 6/1/0", read_data_a, ckpt_valid, busy_restore);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    read_addr_a = 5'd6;
    drive(1, 6, 32'h10, 0, 0); tick();
    drive(1, 6, 32'h77, 0, 0); #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'h77;
`else
    want = 32'h10;
`endif
    tests_run++;
    if (read_data_a !== want) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: got %h want %h", read_data_a, want);
    end
    tick();
    tests_run++;
    if (read_data_a !== 32'h77) begin
      tests_failed++;
      $display("FAIL bypass_next_cycle: got %h want 77", read_data_a);
    end
    drive(0, 0, 0, 1, 0); tick();
    drive(1, 6, 32'h55, 0, 1); #1;
    tests_run++;
    if (read_data_a !== 32'h77) begin
      tests_failed++;
      $display("FAIL bypass_restore_suppress: got %h want 77", read_data_a);
    end
    tick();
    read_addr_a = 5'd0;
    drive(1, 0, 32'hAB, 0, 0); #1;
    tests_run++;
    if (read_data_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL bypass_r0: got %h want 0", read_data_a);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      read_addr_a = 5'($urandom);
      read_addr_b = 5'($urandom);
      drive(1'($urandom), 5'($urandom), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      #1;
      tests_run++;
      if (read_data_a !== exp_read(read_addr_a) || read_data_b !== exp_read(read_addr_b)) begin
        tests_failed++;
        $display("FAIL random_read[%0d]: got a=%h b=%h want a=%h b=%h", n,
                 read_data_a, read_data_b, exp_read(read_addr_a), exp_read(read_addr_b));
      end
      tick();
      tests_run++;
      if (ckpt_valid !== m_valid || busy_restore !== m_busy) begin
        tests_failed++;
        $display("FAIL random_status[%0d]: got valid=%b busy=%b want %b/%b", n,
                 ckpt_valid, busy_restore, m_valid, m_busy);
      end
    end
    for (int i = 0; i < 32; i++) begin
      read_addr_a = 5'(i); #1;
      tests_run++;
      if (read_data_a !== exp_read(5'(i))) begin
        tests_failed++;
        $display("FAIL random_final[%0d]: got %h want %h", i, read_data_a, exp_read(5'(i)));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    read_addr_a = '0;
    read_addr_b = '0;
    drive(0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_basic_write();
    test_ckpt_restore();
    test_restore_write();
    test_swap();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
